// File: rtl/dffr_pkg.sv
// Shared types and helpers for the write arbiter that guards one shared register.
// Contents: FSM state enum, hold counter width, owner-index width function.
package dffr_pkg;

    // IDLE arbitrates and accepts a write; HOLD enforces the post-write gap.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Hold counter width; covers HOLD_CYCLES up to 255.
    localparam int unsigned HOLD_CNT_W = 8;

    // Smallest legal width of an owner index.
    localparam int unsigned OWNER_W_MIN = 1;

    // Owner index width: max(1, clog2(n)).
    function automatic int unsigned owner_w(input int unsigned n);
        return ($clog2(n) > OWNER_W_MIN) ? $clog2(n) : OWNER_W_MIN;
    endfunction

endpackage

// File: rtl/dffr_wr_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter.
//   req_valid : bit i set when requester i offers data
//   req_data  : requester i data in [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready : one-hot or zero grant from the arbiter
// Modports: master = requester side, slave = arbiter side.
interface dffr_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of valid starting at ptr, wrapping.
//   valid     : request vector
//   ptr       : highest-priority index (must be < N)
//   grant     : one-hot pick, zero when no valid
//   grant_idx : index of the pick (0 when no valid)
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic        found;
    int unsigned idx;

    // Walk ptr, ptr+1, ... modulo N and keep the first valid hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/dffr_wr_arbiter.sv
// Round-robin write arbiter in front of a single shared register.
// After each accepted write, grants are withheld for HOLD_CYCLES cycles.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : requester bus (req_valid/req_data in, req_ready out, combinational)
//   q        : shared register contents
//   q_owner  : index of the requester that last wrote q
//   q_update : one-cycle pulse the cycle after q is written
//   busy     : high while in HOLD
module dffr_wr_arbiter
    import dffr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    dffr_wr_arbiter_if.slave             bus,
    output logic [DATA_WIDTH-1:0]        q,
    output logic [owner_w(NUM_REQ)-1:0]  q_owner,
    output logic                         q_update,
    output logic                         busy
);

    localparam int unsigned OW = owner_w(NUM_REQ);
    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD =
        HOLD_CNT_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
    localparam logic [OW-1:0] LAST_IDX = OW'(NUM_REQ - 1);

    state_e                state_q, state_d;
    logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
    logic [OW-1:0]         ptr_q;
    logic [NUM_REQ-1:0]    grant;
    logic [OW-1:0]         grant_idx;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] wr_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (OW)
    ) u_rr (
        .valid     (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants only in IDLE and never while reset is asserted.
    assign bus.req_ready = ((state_q == IDLE) && !rst) ? grant : '0;
    assign xfer          = |bus.req_ready;
    assign busy          = (state_q != IDLE);

    // Select the granted requester's data; one-hot so at most one slice wins.
    always_comb begin
        wr_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i]) begin
                wr_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and hold counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer && (HOLD_CYCLES > 0)) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, pointer and shared register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            q        <= '0;
            q_owner  <= '0;
            q_update <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_update <= xfer;
            if (xfer) begin
                q       <= wr_data;
                q_owner <= grant_idx;
                ptr_q   <= (grant_idx == LAST_IDX) ? '0 : (grant_idx + 1'b1);
            end
        end
    end

endmodule
